mem_loader: RTL
===============

// Module: mem_loader
// PURPOSE
//  Host-side initiator for the CPU external memory ports (instruction and data sram ext ports).
//  Takes a 32-bit command/data stream over valid/ready and writes words into imem/dmem.
//  Streams dmem contents back out over valid/ready and drives the CPU enable input.
//  Sits between the bench/host link and the cpu top-level.
// PARAMETERS
//  IMEM_ADDR_W  9   imem word-address width; addresses wrap modulo 2**IMEM_ADDR_W
//  DMEM_ADDR_W  10  dmem word-address width; addresses wrap modulo 2**DMEM_ADDR_W
// PORTS
//  clk          in   1   single clock, all logic rising-edge
//  arst_n       in   1   asynchronous active-low reset
//  s_valid      in   1   command/payload word valid
//  s_ready      out  1   loader accepts s_data this cycle
//  s_data       in   32  header or payload word
//  m_valid      out  1   dump word valid
//  m_ready      in   1   consumer accepts m_data
//  m_data       out  32  dump word
//  cpu_enable   out  1   to cpu enable
//  busy         out  1   command in progress (header accepted, not finished)
//  err          out  1   one-cycle pulse: write/dump refused while cpu_enable=1
//  addr_ext     out  32  imem byte address (word index << 2)
//  wen_ext / ren_ext out 1  imem write / read strobe
//  wdata_ext    out  32  imem write data
//  rdata_ext    in   32  imem read data (unused, tie-off allowed)
//  addr_ext_2   out  32  dmem byte address (word index << 2)
//  wen_ext_2 / ren_ext_2 out 1  dmem write / read strobe
//  wdata_ext_2  out  32  dmem write data
//  rdata_ext_2  in   32  dmem read data, valid the cycle after ren_ext_2
// BEHAVIOUR
//  Header: [31:30] cmd (00 write imem, 01 write dmem, 10 dump dmem, 11 run), [29:20] count N, [19:0] base word index.
//  States: IDLE, WRITE, DRAIN, RD_REQ, RD_WAIT, RD_OUT. s_ready=1 in IDLE/WRITE/DRAIN, else 0; s_ready=0 while arst_n=0.
//  Reset (async): state IDLE; m_valid, m_data, cpu_enable, busy, err, all wen/ren, addr, wdata = 0.
//  IDLE, header accepted:
//   cmd 00/01, cpu_enable=0, N>0 -> WRITE, busy=1.   cmd 10, cpu_enable=0, N>0 -> RD_REQ, busy=1.
//   cmd 00/01/10 with cpu_enable=1 -> err pulse next cycle; N>0 -> DRAIN (consume N words, no memory access).
//   N=0 for any write/dump -> stay IDLE, no access, busy stays 0.
//   cmd 11: N!=0 -> cpu_enable=1 next cycle; N=0 -> cpu_enable=0 next cycle. Base ignored. No err.
//  WRITE: each accepted payload word i (0..N-1) -> next cycle wen strobe high exactly 1 cycle,
//   addr = ((base+i) mod 2**ADDR_W) << 2, wdata = word. 1 word/cycle sustained; gaps in s_valid give gaps in wen.
//   After word N-1: -> IDLE; busy drops in the cycle its wen pulse is driven ends (busy=0 the cycle after).
//  RD_REQ: ren_ext_2=1 one cycle at ((base+i) mod 2**DMEM_ADDR_W)<<2 -> RD_WAIT.
//  RD_WAIT: capture rdata_ext_2 into m_data, m_valid=1 -> RD_OUT.
//  RD_OUT: m_data/m_valid held stable until m_valid&&m_ready; then i++ ; i<N -> RD_REQ else IDLE, busy=0.
//   Exactly N ren pulses per dump, no reads issued while m_valid pending; throughput 1 word / 3 cycles max.
//  cpu_enable persists across commands; unaffected by err. ren/wen never both high on one port.
//  Reset mid-command: command aborted, pending strobe dropped, next accepted word is a header.
// TESTING
//  T1 hdr 0x0030_0004 (imem, N=3, base 4), words A,B,C back-to-back -> wen_ext 3 consecutive cycles, addr 0x10/0x14/0x18, wdata A/B/C; busy 0 after.
//  T2 preload dmem[0]=0x11,[1]=0x22; hdr 0x8020_0000, m_ready low 5 cycles -> m_data=0x11 held with m_valid, then 0x22; ren_ext_2 exactly 2 pulses.
//  T3 hdr 0xC010_0000 -> cpu_enable=1; hdr 0x4020_0000 + 2 words -> err 1-cycle pulse, both words consumed, no wen_ext_2; hdr 0xC000_0000 -> cpu_enable=0.
//  T4 hdr 0x0020_01FF (imem, N=2, base 511) -> addr_ext 0x7FC then 0x000.
//  T5 arst_n low after 1 of 3 payload words -> all outputs 0 immediately; after release next word 0x0010_0000 treated as header.
//  T6 hdr 0x4000_0005 (N=0) -> no wen_ext_2, busy stays 0, following word decoded as header.

Source files
------------

// File: rtl/mem_loader.sv
// mem_loader: host command stream to imem/dmem ext ports,
// dmem dump stream back out, and cpu enable control.
module mem_loader #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [31:0] wdata_ext_2,
  input  logic [31:0] rdata_ext_2
);

  typedef enum logic [2:0] {
    IDLE, WRITE, DRAIN, RD_REQ, RD_WAIT, RD_OUT
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [19:0] ptr_q, ptr_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        cpu_en_q, cpu_en_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
  logic        wen_i_q, wen_i_d;
  logic [31:0] addr_i_q, addr_i_d;
  logic [31:0] wdata_i_q, wdata_i_d;
  logic        wen_d_q, wen_d_d;
  logic [31:0] addr_d_q, addr_d_d;
  logic [31:0] wdata_d_q, wdata_d_d;

  logic [1:0]  hdr_cmd;
  logic [9:0]  hdr_n;
  logic [19:0] hdr_base;
  logic [19:0] ptr_n;
  logic        hs;
  logic        unused_rdata;

  assign hdr_cmd  = s_data[31:30];
  assign hdr_n    = s_data[29:20];
  assign hdr_base = s_data[19:0];
  assign ptr_n    = ptr_q + 20'd1;
  assign hs       = s_valid && s_ready;
  assign unused_rdata = ^rdata_ext;

  assign s_ready = arst_n &&
    (state_q == IDLE || state_q == WRITE ||
     state_q == DRAIN);

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign cpu_enable  = cpu_en_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign addr_ext    = addr_i_q;
  assign wen_ext     = wen_i_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_i_q;
  assign addr_ext_2  = addr_d_q;
  assign wen_ext_2   = wen_d_q;
  assign ren_ext_2   = (state_q == RD_REQ);
  assign wdata_ext_2 = wdata_d_q;

  // Header decode, payload sequencing and dump handshake.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    cpu_en_d  = cpu_en_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    wen_i_d   = 1'b0;
    addr_i_d  = addr_i_q;
    wdata_i_d = wdata_i_q;
    wen_d_d   = 1'b0;
    addr_d_d  = addr_d_q;
    wdata_d_d = wdata_d_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (hs) begin
          if (hdr_cmd == 2'b11) begin
            cpu_en_d = (hdr_n != 10'd0);
          end else if (cpu_en_q) begin
            err_d = 1'b1;
            if (hdr_n != 10'd0) begin
              cnt_d   = hdr_n;
              busy_d  = 1'b1;
              state_d = DRAIN;
            end
          end else if (hdr_n != 10'd0) begin
            cnt_d  = hdr_n;
            ptr_d  = hdr_base;
            sel_d  = hdr_cmd[0];
            busy_d = 1'b1;
            if (hdr_cmd[1]) begin
              addr_d_d = 32'({hdr_base[DMEM_ADDR_W-1:0], 2'b00});
              state_d  = RD_REQ;
            end else begin
              state_d = WRITE;
            end
          end
        end
      end
      WRITE: begin
        if (s_valid) begin
          if (sel_q) begin
            wen_d_d   = 1'b1;
            addr_d_d  = 32'({ptr_q[DMEM_ADDR_W-1:0], 2'b00});
            wdata_d_d = s_data;
          end else begin
            wen_i_d   = 1'b1;
            addr_i_d  = 32'({ptr_q[IMEM_ADDR_W-1:0], 2'b00});
            wdata_i_d = s_data;
          end
          ptr_d = ptr_n;
          cnt_d = cnt_q - 10'd1;
          if (cnt_q == 10'd1) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (s_valid) begin
          cnt_d = cnt_q - 10'd1;
          if (cnt_q == 10'd1) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        m_data_d  = rdata_ext_2;
        m_valid_d = 1'b1;
        state_d   = RD_OUT;
      end
      RD_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          cnt_d     = cnt_q - 10'd1;
          ptr_d     = ptr_n;
          addr_d_d  = 32'({ptr_n[DMEM_ADDR_W-1:0], 2'b00});
          if (cnt_q == 10'd1) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_en_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      wen_i_q   <= 1'b0;
      addr_i_q  <= '0;
      wdata_i_q <= '0;
      wen_d_q   <= 1'b0;
      addr_d_q  <= '0;
      wdata_d_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      cpu_en_q  <= cpu_en_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      wen_i_q   <= wen_i_d;
      addr_i_q  <= addr_i_d;
      wdata_i_q <= wdata_i_d;
      wen_d_q   <= wen_d_d;
      addr_d_q  <= addr_d_d;
      wdata_d_q <= wdata_d_d;
    end
  end

endmodule
